// File: rtl/fe_ci_if.sv
// Handshake and custom-instruction signal bundle between the stream fabric,
// the sequencer (master) and its environment (slave).
`timescale 1ns/1ps
interface fe_ci_if #(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2,
    parameter int LEN_WIDTH      = 16
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [LEN_WIDTH-1:0]      cmd_len;
    logic                      in_valid;
    logic                      in_ready;
    logic [FLT_DATA_WIDTH-1:0] in_data;
    logic                      res_valid;
    logic                      res_ready;
    logic [FLT_DATA_WIDTH-1:0] res_data;
    logic                      res_err;
    logic                      ci_clk_en;
    logic                      ci_start;
    logic [N_WIDTH-1:0]        ci_n;
    logic [FLT_DATA_WIDTH-1:0] ci_dataa;
    logic [FLT_DATA_WIDTH-1:0] ci_datab;
    logic                      ci_done;
    logic [FLT_DATA_WIDTH-1:0] ci_result;
    logic                      busy;

    modport master (
        input  cmd_valid, cmd_len, in_valid, in_data, res_ready, ci_done, ci_result,
        output cmd_ready, in_ready, res_valid, res_data, res_err,
               ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab, busy
    );

    modport slave (
        output cmd_valid, cmd_len, in_valid, in_data, res_ready, ci_done, ci_result,
        input  cmd_ready, in_ready, res_valid, res_data, res_err,
               ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab, busy
    );
endinterface

// File: rtl/fe_ci_sequencer.sv
// Drives CLEAR / GO-per-element-pair / READ on the function-evaluation
// custom instruction for each vector command and returns the accumulated sum.
`timescale 1ns/1ps
module fe_ci_sequencer #(
    parameter int                        FLT_DATA_WIDTH = 32,
    parameter int                        N_WIDTH        = 2,
    parameter int                        LEN_WIDTH      = 16,
    parameter int                        TIMEOUT_CYCLES = 1024,
    parameter logic [FLT_DATA_WIDTH-1:0] ERR_RESULT     = 32'h7FC00000
) (
    input  logic clk,
    input  logic rst_n,
    fe_ci_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLR, GATH_A, GATH_B, GO, RD, WAIT, RES} state_t;

    localparam int                 WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_WIDTH-1:0] N_CLEAR = N_WIDTH'(0);
    localparam logic [N_WIDTH-1:0] N_GO    = N_WIDTH'(1);
    localparam logic [N_WIDTH-1:0] N_READ  = N_WIDTH'(2);

    state_t                    state_q, state_d;
    state_t                    ret_q, ret_d;
    logic [LEN_WIDTH-1:0]      rem_q, rem_d;
    logic [N_WIDTH-1:0]        n_q, n_d;
    logic [FLT_DATA_WIDTH-1:0] dataa_q, dataa_d;
    logic [FLT_DATA_WIDTH-1:0] datab_q, datab_d;
    logic [FLT_DATA_WIDTH-1:0] res_q, res_d;
    logic                      err_q, err_d;
    logic [WD_W-1:0]           wd_q, wd_d;
    logic                      start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            rem_q   <= '0;
            n_q     <= '0;
            dataa_q <= '0;
            datab_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
            n_q     <= n_d;
            dataa_q <= dataa_d;
            datab_q <= datab_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        rem_d   = rem_q;
        n_d     = n_q;
        dataa_d = dataa_q;
        datab_d = datab_q;
        res_d   = res_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                rem_d   = bus.cmd_len;
                n_d     = N_CLEAR;
                state_d = CLR;
            end
            CLR: begin
                ret_d   = GATH_A;
                wd_d    = WD_W'(1);
                state_d = WAIT;
            end
            GATH_A: begin
                if (rem_q == '0) begin
                    n_d     = N_READ;
                    state_d = RD;
                end else if (bus.in_valid) begin
                    dataa_d = bus.in_data;
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        // odd tail: pad with zero, the accelerator maps 0 to 0
                        datab_d = '0;
                        n_d     = N_GO;
                        state_d = GO;
                    end else begin
                        state_d = GATH_B;
                    end
                end
            end
            GATH_B: if (bus.in_valid) begin
                datab_d = bus.in_data;
                rem_d   = rem_q - LEN_WIDTH'(1);
                n_d     = N_GO;
                state_d = GO;
            end
            GO: begin
                ret_d   = GATH_A;
                wd_d    = WD_W'(1);
                state_d = WAIT;
            end
            RD: begin
                ret_d   = RES;
                wd_d    = WD_W'(1);
                state_d = WAIT;
            end
            WAIT: begin
                // wd_q counts cycles since the start pulse; done wins over expiry
                if (bus.ci_done) begin
                    state_d = ret_q;
                    if (ret_q == RES) begin
                        res_d = bus.ci_result;
                        err_d = 1'b0;
                    end
                end else if (wd_q >= WD_LAST) begin
                    res_d   = ERR_RESULT;
                    err_d   = 1'b1;
                    state_d = RES;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RES: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign start         = (state_q == CLR) || (state_q == GO) || (state_q == RD);
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.in_ready  = ((state_q == GATH_A) && (rem_q != '0)) || (state_q == GATH_B);
    assign bus.res_valid = (state_q == RES);
    assign bus.res_data  = res_q;
    assign bus.res_err   = err_q;
    assign bus.ci_start  = start;
    assign bus.ci_clk_en = start;
    assign bus.ci_n      = n_q;
    assign bus.ci_dataa  = dataa_q;
    assign bus.ci_datab  = datab_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
